// File: rtl/ibuf_fetch_ctl.sv
// Instruction-buffer fetch controller: tracks the byte pointers and the valid count
// of a circular instruction buffer and issues one-at-a-time fetches to the I-cache.
module ibuf_fetch_ctl #(
  parameter  int IBUF_BYTES  = 16,
  parameter  int FETCH_BYTES = 4,
  localparam int PTR_W       = $clog2(IBUF_BYTES),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       iu_shift_onehot,
  input  logic             iu_flush,
  input  logic             icu_ack,
  output logic             icu_req,
  output logic             ibuf_wr_en,
  output logic [PTR_W-1:0] ibuf_wr_ptr,
  output logic [PTR_W-1:0] ibuf_rd_ptr,
  output logic [CNT_W-1:0] ibuf_valid_cnt,
  output logic             shift_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] valid_cnt_q, valid_cnt_d;
  logic             shift_err_q, shift_err_d;

  logic [2:0]       shift_k;
  logic             shift_legal;
  logic [CNT_W-1:0] shift_amt;
  logic [CNT_W-1:0] free_cur;
  logic [CNT_W-1:0] free_nxt;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    shift_k = '0;
    for (int i = 1; i < 8; i++) begin
      if (iu_shift_onehot[i]) shift_k = 3'(i);
    end
    shift_legal = ($countones(iu_shift_onehot) == 1) && (CNT_W'(shift_k) <= valid_cnt_q);
    shift_amt   = shift_legal ? CNT_W'(shift_k) : '0;
  end

  // Reset also masks the write strobe so an ack racing a reset never reaches the buffer.
  assign ibuf_wr_en = (state_q == S_REQ) && icu_ack && !iu_flush && !reset;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    valid_cnt_d = valid_cnt_q;
    shift_err_d = !iu_flush && !shift_legal;

    if (iu_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      valid_cnt_d = '0;
    end else begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(shift_amt);
      valid_cnt_d = valid_cnt_q - shift_amt;
      if (ibuf_wr_en) begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(FETCH_BYTES);
        valid_cnt_d = valid_cnt_d + CNT_W'(FETCH_BYTES);
      end
    end

    free_cur = CNT_W'(IBUF_BYTES) - valid_cnt_q;
    free_nxt = CNT_W'(IBUF_BYTES) - valid_cnt_d;

    case (state_q)
      S_IDLE: begin
        if (!iu_flush && (free_cur >= CNT_W'(FETCH_BYTES))) state_d = S_REQ;
      end
      S_REQ: begin
        if (iu_flush) begin
          state_d = icu_ack ? S_IDLE : S_DISCARD;
        end else if (icu_ack) begin
          state_d = (free_nxt >= CNT_W'(FETCH_BYTES)) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        // The stale ack retires the only outstanding fetch, so it always ends the wait.
        if (icu_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      valid_cnt_q <= '0;
      shift_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      valid_cnt_q <= valid_cnt_d;
      shift_err_q <= shift_err_d;
    end
  end

  assign icu_req        = (state_q == S_REQ);
  assign ibuf_wr_ptr    = wr_ptr_q;
  assign ibuf_rd_ptr    = rd_ptr_q;
  assign ibuf_valid_cnt = valid_cnt_q;
  assign shift_err      = shift_err_q;

endmodule
